// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   Register offsets are word indices. They are decoded from bus_addr[4:2].
//   ID_NONE is the ID that is reported when no source is active.
//   irq_state_e is the state encoding of the claim/EOI handshake FSM.
package irq_pkg;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_CLEAR  = 3'd1;
  localparam logic [2:0] REG_ENABLE = 3'd2;
  localparam logic [2:0] REG_MODE   = 3'd3;
  localparam logic [2:0] REG_CLAIM  = 3'd4;

  localparam int unsigned ID_NONE = 0;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder. This block is purely combinational.
//   req   in  NUM_SRC  active request vector
//   valid out 1        at least one request bit is set
//   id    out ID_W     index+1 of the lowest set bit, or ID_NONE when no bit is set
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int ID_W    = 5
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // The loop scans from the top index down to index 0. Each later hit
  // overwrites the earlier one, so the lowest set index is the one that is kept.
  always_comb begin
    valid = 1'b0;
    id    = ID_W'(ID_NONE);
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_W'(i + 1);
      end
    end
  end

endmodule

// File: rtl/irq_controller_v2.sv
// Parametrised interrupt controller with per-source enable and edge/level mode.
// A fixed-priority pick selects the winning source. A claim/EOI handshake
// masks irq while the CPU services one source.
//   clk        in  1        system clock, rising edge
//   rst        in  1        synchronous active-high reset
//   irq_src    in  NUM_SRC  raw interrupt requests
//   bus_valid  in  1        single-cycle bus access strobe
//   bus_write  in  1        1 = write, 0 = read
//   bus_addr   in  ADDR_W   byte address; bits [4:2] select the register
//   bus_wdata  in  DATA_W   write data
//   bus_rdata  out DATA_W   combinational read data; 0 when the access is not a read
//   irq        out 1        registered interrupt request
//   irq_id     out ID_W     registered ID of the current winner (0 = none)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no source claimed; irq follows (pending & enable)
// ST_SERVICE | CPU owns svc_id; irq is masked until a matching EOI
module irq_controller_v2
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DATA_W  = 19,
  parameter int ADDR_W  = 19,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               bus_valid,
  input  logic               bus_write,
  input  logic [ADDR_W-1:0]  bus_addr,
  input  logic [DATA_W-1:0]  bus_wdata,
  output logic [DATA_W-1:0]  bus_rdata,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id
);

  logic [NUM_SRC-1:0] src_prev;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  irq_state_e         state;
  logic [ID_W-1:0]    svc_id;

  logic [NUM_SRC-1:0] active;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;

  logic [2:0]         reg_off;
  logic               rd_en;
  logic               wr_en;
  logic               claim_rd;
  logic               eoi_wr;
  logic [NUM_SRC-1:0] claim_mask;
  logic [NUM_SRC-1:0] clear_mask;
  logic [NUM_SRC-1:0] edge_set;
  logic [NUM_SRC-1:0] pending_nxt;
  irq_state_e         state_nxt;
  logic [ID_W-1:0]    svc_id_nxt;

  // Only bits [4:2] of the address and the low bits of wdata are decoded.
  logic unused_bus;
  assign unused_bus = ^{bus_addr[ADDR_W-1:5], bus_addr[1:0], bus_wdata};

  assign active = pending & enable;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req   (active),
    .valid (win_valid),
    .id    (win_id)
  );

  assign reg_off = bus_addr[4:2];
  assign rd_en   = bus_valid & ~bus_write;
  assign wr_en   = bus_valid &  bus_write;

  // A claim read takes effect only in IDLE and only when there is a winner.
  // An EOI takes effect only when its ID matches the source in service.
  assign claim_rd = rd_en && (reg_off == REG_CLAIM) && (state == ST_IDLE) && win_valid;
  assign eoi_wr   = wr_en && (reg_off == REG_CLAIM) && (state == ST_SERVICE)
                    && (bus_wdata[ID_W-1:0] == svc_id);

  assign clear_mask = (wr_en && (reg_off == REG_CLEAR)) ? bus_wdata[NUM_SRC-1:0] : '0;
  assign edge_set   = irq_src & ~src_prev;

  always_comb begin
    claim_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_mask[i] = claim_rd && (win_id == ID_W'(i + 1));
    end
  end

  // An edge source holds its bit until CLEAR or claim. A new edge in the same
  // cycle wins over the clear. A level source reloads from irq_src every cycle.
  // So a MODE write from edge to level resamples on the cycle after the write.
  assign pending_nxt = (mode & ((pending & ~(clear_mask | claim_mask)) | edge_set))
                     | (~mode & irq_src);

  always_comb begin
    state_nxt  = state;
    svc_id_nxt = svc_id;
    if (claim_rd) begin
      state_nxt  = ST_SERVICE;
      svc_id_nxt = win_id;
    end else if (eoi_wr) begin
      state_nxt  = ST_IDLE;
      svc_id_nxt = ID_W'(ID_NONE);
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (rd_en) begin
      case (reg_off)
        REG_STATUS: bus_rdata = DATA_W'(pending);
        REG_ENABLE: bus_rdata = DATA_W'(enable);
        REG_MODE:   bus_rdata = DATA_W'(mode);
        REG_CLAIM:  bus_rdata = (state == ST_SERVICE) ? DATA_W'(svc_id) : DATA_W'(win_id);
        default:    bus_rdata = '0;
      endcase
    end
  end

  // irq looks at the next state. This makes irq drop the cycle after a claim
  // and return the cycle after an EOI. It looks at the registered pending,
  // which gives the two-cycle path from an irq_src edge to irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_prev <= '0;
      pending  <= '0;
      enable   <= '0;
      mode     <= '1;
      state    <= ST_IDLE;
      svc_id   <= ID_W'(ID_NONE);
      irq      <= 1'b0;
      irq_id   <= ID_W'(ID_NONE);
    end else begin
      src_prev <= irq_src;
      pending  <= pending_nxt;
      if (wr_en && (reg_off == REG_ENABLE)) begin
        enable <= bus_wdata[NUM_SRC-1:0];
      end
      if (wr_en && (reg_off == REG_MODE)) begin
        mode <= bus_wdata[NUM_SRC-1:0];
      end
      state  <= state_nxt;
      svc_id <= svc_id_nxt;
      irq    <= (state_nxt == ST_IDLE) && win_valid;
      irq_id <= win_id;
    end
  end

endmodule
